pixel_array_readout_ctrl: RTL and testbench

Parametrised sequencer and readout engine for an N_ROWS x N_COLS digital pixel array. It generates the erase/expose/convert/per-row read phases and the digital ramp code driven onto the column buses during conversion. It captures each row's column data and streams it out one pixel per transfer over a valid/ready interface. It sits between the pixel array, the ramp/bias generators, and the downstream frame sink, and supersedes the fixed 2x2, two-read-line arrangement.

---
 rtl/pixel_array_readout_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_pixel_array_readout_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_readout_ctrl.sv
// pixel_array_readout_ctrl
// Sequencer and readout engine for an N_ROWS x N_COLS digital pixel array.
// A frame runs ERASE -> EXPOSE -> CONVERT, then for every row a READ settle
// window followed by a STREAM of that row's pixels, one per valid/ready
// transfer. The ramp code is generated here; the column buses themselves are
// tri-stated by the top level using ramp_drive.
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   start             : begin a frame (honoured only in IDLE)
//   continuous        : restart at ERASE after the last transfer of a frame
//   erase/expose/convert : registered, mutually exclusive phase strobes
//   ramp_code/ramp_drive : conversion ramp and its bus-drive enable
//   read              : one-hot read-line select
//   col_data          : column buses, column c at [c*DATA_W +: DATA_W]
//   out_valid/out_ready/out_data/out_row/out_col/out_last : pixel stream
//   busy              : high in every state except IDLE
//   frame_done        : one-cycle pulse after the final pixel transfer
module pixel_array_readout_ctrl #(
  parameter int DATA_W    = 8,
  parameter int N_ROWS    = 2,
  parameter int N_COLS    = 2,
  parameter int C_ERASE   = 5,
  parameter int C_EXPOSE  = 255,
  parameter int C_CONVERT = 255,
  parameter int C_READ    = 5,
  localparam int ROW_W = $clog2((N_ROWS > 2) ? N_ROWS : 2),
  localparam int COL_W = $clog2((N_COLS > 2) ? N_COLS : 2)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     continuous,
  output logic                     erase,
  output logic                     expose,
  output logic                     convert,
  output logic [DATA_W-1:0]        ramp_code,
  output logic                     ramp_drive,
  output logic [N_ROWS-1:0]        read,
  input  logic [N_COLS*DATA_W-1:0] col_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ROW_W-1:0]         out_row,
  output logic [COL_W-1:0]         out_col,
  output logic                     out_last,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int C_M1  = (C_ERASE > C_EXPOSE) ? C_ERASE : C_EXPOSE;
  localparam int C_M2  = (C_CONVERT > C_READ) ? C_CONVERT : C_READ;
  localparam int C_MAX = (C_M1 > C_M2) ? C_M1 : C_M2;
  localparam int CNT_W = $clog2(C_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_STREAM
  } state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [ROW_W-1:0]          r_row;
  logic [COL_W-1:0]          r_col;
  logic [N_COLS*DATA_W-1:0]  r_buf;
  logic                      r_erase;
  logic                      r_expose;
  logic                      r_convert;
  logic [DATA_W-1:0]         r_ramp;
  logic                      r_drive;
  logic [N_ROWS-1:0]         r_read;
  logic                      r_valid;
  logic [DATA_W-1:0]         r_data;
  logic                      r_last;
  logic                      r_busy;
  logic                      r_done;

  logic                      w_row_last;
  logic                      w_col_last;
  logic                      w_xfer;
  logic [ROW_W-1:0]          w_row_nxt;
  logic [COL_W-1:0]          w_col_nxt;

  // Ramp stops at full scale rather than wrapping back to zero.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [N_ROWS-1:0] onehot(input logic [ROW_W-1:0] r);
    logic [N_ROWS-1:0] o;
    o = '0;
    for (int i = 0; i < N_ROWS; i++) o[i] = (ROW_W'(i) == r);
    return o;
  endfunction

  // Column select from the line buffer without out-of-range part selects.
  function automatic logic [DATA_W-1:0] pick(input logic [N_COLS*DATA_W-1:0] v,
                                             input logic [COL_W-1:0] idx);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int c = 0; c < N_COLS; c++)
      if (COL_W'(c) == idx) p = v[c*DATA_W +: DATA_W];
    return p;
  endfunction

  assign w_row_last = (r_row == ROW_W'(N_ROWS - 1));
  assign w_col_last = (r_col == COL_W'(N_COLS - 1));
  assign w_xfer     = r_valid && out_ready;
  assign w_row_nxt  = r_row + 1'b1;
  assign w_col_nxt  = r_col + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_buf     <= '0;
      r_erase   <= 1'b0;
      r_expose  <= 1'b0;
      r_convert <= 1'b0;
      r_ramp    <= '0;
      r_drive   <= 1'b0;
      r_read    <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ERASE;
            r_cnt   <= '0;
            r_erase <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_ERASE: begin
          if (r_cnt == CNT_W'(C_ERASE - 1)) begin
            r_state  <= S_EXPOSE;
            r_cnt    <= '0;
            r_erase  <= 1'b0;
            r_expose <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EXPOSE: begin
          if (r_cnt == CNT_W'(C_EXPOSE - 1)) begin
            r_state   <= S_CONVERT;
            r_cnt     <= '0;
            r_expose  <= 1'b0;
            r_convert <= 1'b1;
            r_drive   <= 1'b1;
            r_ramp    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CONVERT: begin
          if (r_cnt == CNT_W'(C_CONVERT - 1)) begin
            r_state   <= S_READ;
            r_cnt     <= '0;
            r_convert <= 1'b0;
            r_drive   <= 1'b0;
            r_ramp    <= '0;
            r_row     <= '0;
            r_read    <= onehot('0);
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_ramp <= sat_inc(r_ramp);
          end
        end
        S_READ: begin
          // Columns are sampled at the end of the settle window.
          if (r_cnt == CNT_W'(C_READ - 1)) begin
            r_state <= S_STREAM;
            r_cnt   <= '0;
            r_buf   <= col_data;
            r_read  <= '0;
            r_valid <= 1'b1;
            r_col   <= '0;
            r_data  <= col_data[DATA_W-1:0];
            r_last  <= w_row_last && (N_COLS == 1);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (w_col_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_data  <= '0;
              r_col   <= '0;
              if (!w_row_last) begin
                r_state <= S_READ;
                r_cnt   <= '0;
                r_row   <= w_row_nxt;
                r_read  <= onehot(w_row_nxt);
              end else begin
                r_done <= 1'b1;
                r_row  <= '0;
                r_cnt  <= '0;
                if (continuous) begin
                  r_state <= S_ERASE;
                  r_erase <= 1'b1;
                end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                end
              end
            end else begin
              r_col  <= w_col_nxt;
              r_data <= pick(r_buf, w_col_nxt);
              r_last <= w_row_last && (w_col_nxt == COL_W'(N_COLS - 1));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign erase      = r_erase;
  assign expose     = r_expose;
  assign convert    = r_convert;
  assign ramp_code  = r_ramp;
  assign ramp_drive = r_drive;
  assign read       = r_read;
  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_row    = r_row;
  assign out_col    = r_col;
  assign out_last   = r_last;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_pixel_array_readout_ctrl.sv
// Testbench for pixel_array_readout_ctrl: a 2x3 array (DATA_W=4) driven by a
// directed vector table, a frame-level reference model with random and
// scripted stimulus, mid-frame resets, and a 1x1 degenerate instance.
module tb_pixel_array_readout_ctrl;

  localparam int DW = 4, NR = 2, NC = 3, CE = 2, CX = 3, CC = 20, CR = 2;
  localparam int BE = 1, BX = 1, BC = 3, BR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, cont = 1'b0, rdy = 1'b1;
  logic [NC*DW-1:0] cd = '0;
  logic erase, expose, convert, ramp_drive, out_valid, out_last, busy, frame_done;
  logic [DW-1:0] ramp_code, out_data;
  logic [NR-1:0] read;
  logic [0:0] out_row;
  logic [1:0] out_col;

  logic start_b = 1'b0, rdy_b = 1'b1;
  logic [DW-1:0] cd_b = '0;
  logic erase_b, expose_b, convert_b, drive_b, valid_b, last_b, busy_b, done_b;
  logic [DW-1:0] ramp_b, data_b;
  logic [0:0] read_b, row_b, col_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pixel_array_readout_ctrl #(.DATA_W(DW), .N_ROWS(NR), .N_COLS(NC), .C_ERASE(CE),
    .C_EXPOSE(CX), .C_CONVERT(CC), .C_READ(CR)) dut (
    .clk(clk), .reset(rst_n), .start(start), .continuous(cont),
    .erase(erase), .expose(expose), .convert(convert), .ramp_code(ramp_code),
    .ramp_drive(ramp_drive), .read(read), .col_data(cd), .out_valid(out_valid),
    .out_ready(rdy), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy), .frame_done(frame_done));

  pixel_array_readout_ctrl #(.DATA_W(DW), .N_ROWS(1), .N_COLS(1), .C_ERASE(BE),
    .C_EXPOSE(BX), .C_CONVERT(BC), .C_READ(BR)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .continuous(1'b0),
    .erase(erase_b), .expose(expose_b), .convert(convert_b), .ramp_code(ramp_b),
    .ramp_drive(drive_b), .read(read_b), .col_data(cd_b), .out_valid(valid_b),
    .out_ready(rdy_b), .out_data(data_b), .out_row(row_b), .out_col(col_b),
    .out_last(last_b), .busy(busy_b), .frame_done(done_b));

  typedef struct packed {
    logic er, xp, cv;
    logic [3:0] rp;
    logic dr;
    logic [1:0] rd;
    logic v;
    logic [3:0] d;
    logic r;
    logic [1:0] c;
    logic l, b, fd;
  } obs_t;

  typedef struct {
    int cyc;
    logic st;
    logic [11:0] cd;
    obs_t ex;
  } vec_t;

  typedef struct {
    int ph;
    int ramp;
    int row;
    int col;
    int d;
    logic [11:0] vec;
    bit last;
  } item_t;

  vec_t tbl[22];
  item_t mq[$];

  // p: 0 idle, 1 erase, 2 expose, 3 convert, 4 read, 5 stream
  function automatic obs_t mk(input int p, input int rp, input int rd, input int d,
                              input int r, input int c, input bit l, input bit fd);
    obs_t o;
    o.er = (p == 1); o.xp = (p == 2); o.cv = (p == 3);
    o.rp = 4'(rp); o.dr = (p == 3); o.rd = 2'(rd); o.v = (p == 5);
    o.d = 4'(d); o.r = 1'(r); o.c = 2'(c); o.l = l; o.b = (p != 0); o.fd = fd;
    return o;
  endfunction

  function automatic obs_t obs_a();
    obs_t o;
    o.er = erase; o.xp = expose; o.cv = convert; o.rp = ramp_code; o.dr = ramp_drive;
    o.rd = read; o.v = out_valid; o.d = out_data; o.r = out_row; o.c = out_col;
    o.l = out_last; o.b = busy; o.fd = frame_done;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_obs(input string nm, input obs_t a, input obs_t e, input bit full);
    logic [63:0] xa, xe;
    if (!full && !e.v) begin
      a.d = '0; a.r = '0; a.c = '0;
      e.d = '0; e.r = '0; e.c = '0;
    end
    xa = '0; xe = '0;
    xa[$bits(obs_t)-1:0] = a;
    xe[$bits(obs_t)-1:0] = e;
    chk(nm, xa, xe);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_frame();
    logic [11:0] rv[NR];
    int maxc;
    maxc = (1 << DW) - 1;
    for (int r = 0; r < NR; r++) rv[r] = 12'($urandom);
    for (int i = 0; i < CE; i++) mq.push_back('{1, 0, 0, 0, 0, 12'h0, 1'b0});
    for (int i = 0; i < CX; i++) mq.push_back('{2, 0, 0, 0, 0, 12'h0, 1'b0});
    for (int i = 0; i < CC; i++) mq.push_back('{3, (i < maxc) ? i : maxc, 0, 0, 0, 12'h0, 1'b0});
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < CR; i++) mq.push_back('{4, 0, r, 0, 0, rv[r], 1'b0});
      for (int c = 0; c < NC; c++)
        mq.push_back('{5, 0, r, c, int'(rv[r][c*DW +: DW]), 12'h0,
                       (r == NR - 1) && (c == NC - 1)});
    end
  endfunction

  // rmode: 0 always ready, 1 random, 2 ten-cycle stall on the 2nd word
  // cmode: 0 never, 1 random, 2 only for the first frame end
  // smode: 0 start at first cycle only, 1 random, 2 held high
  task automatic run_model(input int ncyc, input int rmode, input int cmode,
                           input int smode, input string nm, output int xfers);
    obs_t e;
    item_t h;
    bit have, pend, drain, r, c, s, cont_used;
    int k, stalls;
    mq.delete();
    pend = 0; k = 0; stalls = 0; cont_used = 0; xfers = 0;
    while ((k < ncyc || mq.size() > 0 || pend) && k < ncyc + 3000) begin
      have = (mq.size() > 0);
      if (have) h = mq[0];
      if (have)
        e = mk(h.ph, h.ramp, (h.ph == 4) ? (1 << h.row) : 0, h.d, h.row, h.col, h.last, pend);
      else
        e = mk(0, 0, 0, 0, 0, 0, 1'b0, pend);
      chk_obs($sformatf("%s_k%0d", nm, k), obs_a(), e, 1'b0);
      pend = 0;
      drain = (k >= ncyc);
      r = 1'b1;
      if (rmode == 1 && !drain) r = 1'($urandom_range(0, 1));
      if (rmode == 2 && have && h.ph == 5 && h.row == 0 && h.col == 1 && stalls < 10) begin
        r = 1'b0;
        stalls++;
      end
      c = 1'b0;
      if (cmode == 1) c = 1'($urandom_range(0, 1));
      if (cmode == 2) c = !cont_used;
      if (drain) c = 1'b0;
      s = 1'b0;
      if (smode == 0) s = (k == 0);
      if (smode == 1) s = ($urandom_range(0, 3) == 0);
      if (smode == 2) s = 1'b1;
      if (drain) s = 1'b0;
      rdy = r; cont = c; start = s;
      cd = (have && h.ph == 4) ? h.vec : 12'($urandom);
      if (!have) begin
        if (s) push_frame();
      end else if (h.ph == 5) begin
        if (r) begin
          void'(mq.pop_front());
          xfers++;
          if (h.last) begin
            pend = 1;
            if (c) begin
              cont_used = 1;
              push_frame();
            end
          end
        end
      end else begin
        void'(mq.pop_front());
      end
      step();
      k++;
    end
    chk($sformatf("%s_drained", nm), 64'((mq.size() == 0) && !pend), 64'd1);
    rdy = 1'b1; cont = 1'b0; start = 1'b0;
  endtask

  function automatic void init_tbl();
    logic [11:0] r0, r1;
    r0 = 12'hA53;
    r1 = 12'hC91;
    tbl[0]  = '{0,  1'b1, r0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1,  1'b0, r0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{2,  1'b0, r0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{3,  1'b0, r0, mk(2, 0, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{5,  1'b0, r0, mk(2, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{6,  1'b0, r0, mk(3, 0, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{7,  1'b0, r0, mk(3, 1, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{21, 1'b0, r0, mk(3, 15, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{22, 1'b0, r0, mk(3, 15, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{25, 1'b0, r0, mk(3, 15, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{26, 1'b0, r0, mk(4, 0, 1, 0, 0, 0, 0, 0)};
    tbl[11] = '{27, 1'b0, r0, mk(4, 0, 1, 0, 0, 0, 0, 0)};
    tbl[12] = '{28, 1'b0, r0, mk(5, 0, 0, 3, 0, 0, 0, 0)};
    tbl[13] = '{29, 1'b0, r1, mk(5, 0, 0, 5, 0, 1, 0, 0)};
    tbl[14] = '{30, 1'b0, r1, mk(5, 0, 0, 10, 0, 2, 0, 0)};
    tbl[15] = '{31, 1'b0, r1, mk(4, 0, 2, 0, 0, 0, 0, 0)};
    tbl[16] = '{32, 1'b0, r1, mk(4, 0, 2, 0, 0, 0, 0, 0)};
    tbl[17] = '{33, 1'b0, r1, mk(5, 0, 0, 1, 1, 0, 0, 0)};
    tbl[18] = '{34, 1'b0, r1, mk(5, 0, 0, 9, 1, 1, 0, 0)};
    tbl[19] = '{35, 1'b0, r1, mk(5, 0, 0, 12, 1, 2, 1, 0)};
    tbl[20] = '{36, 1'b0, r1, mk(0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[21] = '{37, 1'b0, r1, mk(0, 0, 0, 0, 0, 0, 0, 0)};
  endfunction

  function automatic logic [18:0] obs_b();
    return {erase_b, expose_b, convert_b, ramp_b, drive_b, read_b, valid_b,
            valid_b ? data_b : 4'h0, row_b, col_b, last_b, busy_b, done_b};
  endfunction

  initial begin
    int k, x, w;
    obs_t idle;
    logic [DW-1:0] pix;
    logic [18:0] eb;
    init_tbl();
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);

    #2;
    chk_obs("reset_state", obs_a(), idle, 1'b1);
    chk("reset_state_b", {45'd0, obs_b()}, 64'd0);
    #5 rst_n = 1'b1;
    step();

    // Directed table: phase timing and readout order
    k = 0;
    for (int i = 0; i < 22; i++) begin
      while (k < tbl[i].cyc) begin
        step();
        k++;
      end
      start = tbl[i].st;
      cd = tbl[i].cd;
      chk_obs($sformatf("vec%0d_c%0d", i, tbl[i].cyc), obs_a(), tbl[i].ex, 1'b0);
    end
    start = 1'b0;
    step();

    // Backpressure on the second word
    run_model(1, 2, 0, 0, "bp", x);
    chk("bp_words", 64'(x), 64'd6);

    // Continuous restart with start held high (ignored outside IDLE)
    run_model(70, 0, 2, 2, "cont", x);
    chk("cont_words", 64'(x), 64'd12);

    // Random ready/continuous/start against the model
    run_model(600, 1, 1, 1, "rand", x);

    // Reset during EXPOSE
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk_obs("pre_rst_expose", obs_a(), mk(2, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_obs("rst_expose", obs_a(), idle, 1'b1);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_obs($sformatf("rst_expose_idle%0d", i), obs_a(), idle, 1'b0);
    end
    run_model(1, 0, 0, 0, "after_rst1", x);

    // Reset during a stalled STREAM
    rdy = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    w = 0;
    while (!out_valid && w < 80) begin
      step();
      w++;
    end
    chk("stall_reach", 64'(out_valid), 64'd1);
    pix = out_data;
    for (int i = 0; i < 3; i++) step();
    chk("stall_hold", {59'd0, out_valid, read, out_data === pix, out_col}, {59'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0});
    #2 rst_n = 1'b0;
    #1 chk_obs("rst_stream", obs_a(), idle, 1'b1);
    #3 rst_n = 1'b1;
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_obs($sformatf("rst_stream_idle%0d", i), obs_a(), idle, 1'b0);
    end
    run_model(1, 0, 0, 0, "after_rst2", x);

    // Degenerate 1x1 array
    cd_b = 4'($urandom);
    for (int c = 0; c <= BE + BX + BC + BR + 3; c++) begin
      bit er, xp, cv, rd, v, fd, b;
      int rp;
      er = (c >= 1) && (c < 1 + BE);
      xp = (c >= 1 + BE) && (c < 1 + BE + BX);
      cv = (c >= 1 + BE + BX) && (c < 1 + BE + BX + BC);
      rp = cv ? c - (1 + BE + BX) : 0;
      rd = (c >= 1 + BE + BX + BC) && (c < 1 + BE + BX + BC + BR);
      v  = (c == 1 + BE + BX + BC + BR);
      fd = (c == 2 + BE + BX + BC + BR);
      b  = (c >= 1) && (c <= 1 + BE + BX + BC + BR);
      eb = {er, xp, cv, 4'(rp), cv, rd, v, v ? cd_b : 4'h0, 1'b0, 1'b0, v, b, fd};
      start_b = (c == 0);
      chk($sformatf("deg_c%0d", c), {45'd0, obs_b()}, {45'd0, eb});
      step();
    end
    start_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
